jk_cmd_arbiter: RTL

//  Round-robin command arbiter and sequencer for a WIDTH-bit bank of JK flip-flops.

---
 rtl/jk_pkg.sv | 31 +++
 rtl/jk_bank.sv | 31 +++
 rtl/jk_cmd_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/jk_pkg.sv
// Shared definitions for the JK command arbiter: operation codes, FSM
// state encoding and the per-bit j/k encoder.
package jk_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_RST  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_TGL  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_DRIVE  = 2'b01,
    S_SETTLE = 2'b10
  } state_t;

  // Returns {j, k} for one bank bit given the op code and that bit's mask.
  // An unmasked bit always gets j=k=0 so the flop simply holds.
  function automatic logic [1:0] jk_bit(input logic [1:0] code, input logic m);
    logic [1:0] jk;
    jk = 2'b00;
    case (code)
      OP_HOLD: jk = 2'b00;
      OP_RST:  jk = {1'b0, m};
      OP_SET:  jk = {m, 1'b0};
      OP_TGL:  jk = {m, m};
      default: jk = 2'b00;
    endcase
    return jk;
  endfunction

endpackage

// File: rtl/jk_bank.sv
// Bank of WIDTH JK flip-flops with synchronous active-low reset.
module jk_bank #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Classic JK next state per bit: set, reset, toggle or hold.
  always_comb begin
    q_d = (j & ~k) | (q_q & ~j & ~k) | (~q_q & j & k);
  end

  // Bank storage, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/jk_cmd_arbiter.sv
// Round-robin arbiter and sequencer that applies one requester's JK bank
// operation at a time: grant/drive for one cycle, then report completion.
module jk_cmd_arbiter
  import jk_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [2*NREQ-1:0]     op,
  input  logic [WIDTH*NREQ-1:0] mask,
  output logic [NREQ-1:0]       gnt,
  output logic                  done,
  output logic                  busy,
  output logic [WIDTH-1:0]      j,
  output logic [WIDTH-1:0]      k,
  output logic [WIDTH-1:0]      q
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [WIDTH-1:0]  j_q, j_d;
  logic [WIDTH-1:0]  k_q, k_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]  win_q, win_d;

  logic [NREQ-1:0]   req_eff;
  logic              any_req;
  logic [PTR_W-1:0]  pick;
  logic [PTR_W-1:0]  idx;
  logic [1:0]        op_w;
  logic [WIDTH-1:0]  mask_w;
  logic [WIDTH-1:0]  enc_j;
  logic [WIDTH-1:0]  enc_k;

  // Round-robin pick starting at rr_ptr; the requester just served is masked in SETTLE.
  always_comb begin
    req_eff = req;
    if (state_q == S_SETTLE) begin
      req_eff[win_q] = 1'b0;
    end
    any_req = 1'b0;
    pick    = '0;
    idx     = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = PTR_W'((int'(rr_ptr_q) + i) % NREQ);
      if (!any_req && req_eff[idx]) begin
        any_req = 1'b1;
        pick    = idx;
      end
    end
  end

  // Encode the winner's op and mask into bank j/k vectors.
  always_comb begin
    op_w   = op[2*int'(pick) +: 2];
    mask_w = mask[WIDTH*int'(pick) +: WIDTH];
    enc_j  = '0;
    enc_k  = '0;
    for (int b = 0; b < WIDTH; b++) begin
      {enc_j[b], enc_k[b]} = jk_bit(op_w, mask_w[b]);
    end
  end

  // FSM next state and next registered outputs.
  always_comb begin
    state_d  = state_q;
    gnt_d    = '0;
    j_d      = '0;
    k_d      = '0;
    done_d   = 1'b0;
    busy_d   = 1'b0;
    rr_ptr_d = rr_ptr_q;
    win_d    = win_q;
    case (state_q)
      S_IDLE, S_SETTLE: begin
        if (any_req) begin
          state_d     = S_DRIVE;
          gnt_d[pick] = 1'b1;
          j_d         = enc_j;
          k_d         = enc_k;
          win_d       = pick;
          busy_d      = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRIVE: begin
        state_d  = S_SETTLE;
        done_d   = 1'b1;
        busy_d   = 1'b1;
        rr_ptr_d = (win_q == PTR_W'(NREQ - 1)) ? '0 : win_q + 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      j_q      <= '0;
      k_q      <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      rr_ptr_q <= '0;
      win_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      j_q      <= j_d;
      k_q      <= k_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      rr_ptr_q <= rr_ptr_d;
      win_q    <= win_d;
    end
  end

  jk_bank #(
    .WIDTH(WIDTH)
  ) u_bank (
    .clk  (clk),
    .rst_n(rst_n),
    .j    (j_q),
    .k    (k_q),
    .q    (q)
  );

  assign gnt  = gnt_q;
  assign j    = j_q;
  assign k    = k_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule
